// File: rtl/ic1337_pkg.sv
// Shared constants, FSM encoding and device behaviour helpers for the ic1337 driver.
// The device state is always written {Q1,Q0}.
package ic1337_pkg;

  localparam logic [2:0] CODE_SET01 = 3'b001;
  localparam logic [2:0] CODE_SET10 = 3'b101;
  localparam logic [2:0] CODE_CLRQ1 = 3'b011;
  localparam logic [2:0] CODE_TOG   = 3'b010;
  localparam logic [2:0] CODE_Q0CLR = 3'b000;

  typedef enum logic [2:0] {
    S_INIT1,
    S_INIT2,
    S_IDLE,
    S_STEP,
    S_SETTLE,
    S_DONE
  } drv_state_e;

  // One device clock step: the state the device holds after seeing code for a cycle.
  function automatic logic [1:0] ic1337_next(input logic [1:0] state, input logic [2:0] code);
    logic [1:0] nxt;
    case (code)
      CODE_SET01: nxt = 2'b01;
      CODE_TOG:   nxt = ~state;
      CODE_CLRQ1: nxt = {1'b0, state[0]};
      CODE_SET10: nxt = 2'b10;
      default:    nxt = {~state[1], 1'b0};
    endcase
    return nxt;
  endfunction

  // 11 has no hold code; it falls back to SET10, which is only ever seen during init.
  function automatic logic [2:0] park_code(input logic [1:0] state);
    logic [2:0] code;
    case (state)
      2'b00:   code = CODE_CLRQ1;
      2'b01:   code = CODE_SET01;
      default: code = CODE_SET10;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/ic1337_driver_route.sv
// Combinational route planner: code sequence taking the modelled state to the target.
// Only 01->00 needs an intermediate stop (via 10).
module ic1337_route
  import ic1337_pkg::*;
(
  input  logic [1:0] model,
  input  logic [1:0] target,
  output logic [2:0] code1,
  output logic [2:0] code2,
  output logic [1:0] nsteps
);

  always_comb begin
    code1  = CODE_CLRQ1;
    code2  = CODE_CLRQ1;
    nsteps = 2'd0;
    if ((target != model) && (target != 2'b11)) begin
      nsteps = 2'd1;
      case (target)
        2'b01: code1 = CODE_SET01;
        2'b10: code1 = CODE_SET10;
        default: begin
          if (model == 2'b11) begin
            code1 = CODE_Q0CLR;
          end else if (model == 2'b01) begin
            code1  = CODE_SET10;
            code2  = CODE_CLRQ1;
            nsteps = 2'd2;
          end else begin
            code1 = CODE_CLRQ1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/ic1337_driver.sv
// Command-side driver for the ic1337 two-flop device: init sequence, routed moves,
// park codes while idle, and a Z-output consistency checker against the state model.
module ic1337_driver
  import ic1337_pkg::*;
#(
  parameter int SETTLE = 1,
  parameter int ERRW   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_target,
  output logic            A0,
  output logic            A1,
  output logic            A2,
  input  logic            dev_z,
  output logic            done,
  output logic            err_target,
  output logic            z_mismatch,
  output logic [ERRW-1:0] mismatch_cnt,
  output logic [1:0]      state_model
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  drv_state_e    state_q, state_d;
  logic [2:0]    a_q, a_d;
  logic [1:0]    model_q, model_d;
  logic [2:0]    code2_q, code2_d;
  logic          more_q, more_d;
  logic [SW-1:0] settle_q, settle_d;
  logic          err_q, err_d;
  logic          zm_q, zm_d;
  logic [ERRW-1:0] cnt_q, cnt_d;

  logic [2:0] r_code1, r_code2;
  logic [1:0] r_nsteps;
  logic       idle_like;
  logic       accept;

  ic1337_route u_route (
    .model  (model_q),
    .target (cmd_target),
    .code1  (r_code1),
    .code2  (r_code2),
    .nsteps (r_nsteps)
  );

  // DONE behaves as IDLE for acceptance so a new command can follow with no gap.
  assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
  assign accept    = cmd_valid && idle_like;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    model_d  = model_q;
    code2_d  = code2_q;
    more_d   = more_q;
    settle_d = settle_q;
    err_d    = 1'b0;
    zm_d     = zm_q;
    cnt_d    = cnt_q;

    case (state_q)
      S_INIT1: begin
        model_d = 2'b10;
        a_d     = CODE_CLRQ1;
        state_d = S_INIT2;
      end
      S_INIT2: begin
        model_d = 2'b00;
        a_d     = CODE_CLRQ1;
        state_d = S_IDLE;
      end
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        a_d     = park_code(model_q);
        if (accept) begin
          if (cmd_target == 2'b11) begin
            err_d = 1'b1;
          end else if (r_nsteps == 2'd0) begin
            state_d  = S_SETTLE;
            settle_d = '0;
          end else begin
            a_d     = r_code1;
            code2_d = r_code2;
            more_d  = (r_nsteps == 2'd2);
            state_d = S_STEP;
          end
        end
      end
      S_STEP: begin
        // The model advances on the same edge the device sees the end of the code.
        model_d = ic1337_next(model_q, a_q);
        if (more_q) begin
          a_d    = code2_q;
          more_d = 1'b0;
        end else begin
          a_d      = park_code(model_d);
          state_d  = S_SETTLE;
          settle_d = '0;
        end
      end
      S_SETTLE: begin
        if (settle_q == SW'(SETTLE - 1)) begin
          state_d = S_DONE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      default: state_d = S_INIT1;
    endcase

    if ((state_q != S_INIT1) && (state_q != S_INIT2) && (dev_z != ~^model_q)) begin
      zm_d = 1'b1;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_INIT1;
      a_q      <= CODE_SET10;
      model_q  <= 2'b11;
      code2_q  <= CODE_CLRQ1;
      more_q   <= 1'b0;
      settle_q <= '0;
      err_q    <= 1'b0;
      zm_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      model_q  <= model_d;
      code2_q  <= code2_d;
      more_q   <= more_d;
      settle_q <= settle_d;
      err_q    <= err_d;
      zm_q     <= zm_d;
      cnt_q    <= cnt_d;
    end
  end

  assign cmd_ready    = idle_like;
  assign {A2, A1, A0} = a_q;
  assign done         = (state_q == S_DONE);
  assign err_target   = err_q;
  assign z_mismatch   = zm_q;
  assign mismatch_cnt = cnt_q;
  assign state_model  = model_q;

endmodule
